// File: rtl/level_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// level_sensor_conditioner
//
// Purpose:
//   Conditions the three raw level-sensor switches that feed the pump-control
//   FSM. It synchronises and debounces each switch, publishes the stable
//   levels with a one-cycle change strobe, and raises a sticky fault when the
//   tank sensors stay inconsistent: max reads wet while min reads dry.
//
// Ports:
//   clk_2          in   1  system clock; the whole block runs in this domain
//   reset          in   1  synchronous, active-high reset
//   sens_raw       in   3  raw switches: [0] cistern min, [1] tank max, [2] tank min
//   sens_stable    out  3  debounced levels, same bit order as sens_raw
//   sens_valid     out  1  high once the startup fill has completed
//   sens_change    out  1  one-cycle pulse after any sens_stable bit updates
//   fault          out  1  sticky tank-sensor inconsistency flag
//   fault_snapshot out  3  sens_stable captured on the edge where fault rises
//   glitch_cnt     out  8  (LSC_GLITCH_CNT_EN only) saturating count of
//                          rejected glitches
//
// Optional feature:
//   Define LSC_GLITCH_CNT_EN to add the glitch_cnt output and its counter.
// -----------------------------------------------------------------------------
module level_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int FAULT_PERSIST   = 2
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [2:0] sens_raw,
  output logic [2:0] sens_stable,
  output logic       sens_valid,
  output logic       sens_change,
  output logic       fault,
  output logic [2:0] fault_snapshot
`ifdef LSC_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int PCNT_W = (FAULT_PERSIST > 1) ? $clog2(FAULT_PERSIST) : 1;

  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(DEBOUNCE_CYCLES + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(FAULT_PERSIST - 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                  state;
  logic [2:0]              sync1;
  logic [2:0]              sync2;
  logic [CNT_W-1:0]        init_cnt;
  logic [2:0][CNT_W-1:0]   cnt;
  logic [PCNT_W-1:0]       pcnt;

  logic [2:0]              deb_stable;
  logic [2:0]              deb_update;
  logic [2:0][CNT_W-1:0]   deb_cnt;
  logic                    inconsistent;

  // Two-flop synchroniser per switch. Nothing downstream looks at sync1.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sens_raw;
      sync2 <= sync1;
    end
  end

  // Next-state debounce for each channel. A channel's counter runs while
  // sync2 disagrees with the stable level. The level flips on the
  // DEBOUNCE_CYCLES-th consecutive disagreeing edge. Any agreement resets
  // the run.
  always_comb begin
    deb_stable = sens_stable;
    deb_update = '0;
    for (int i = 0; i < 3; i++) begin
      deb_cnt[i] = '0;
      if (sync2[i] != sens_stable[i]) begin
        if (cnt[i] == DEB_LAST) begin
          deb_stable[i] = sync2[i];
          deb_update[i] = 1'b1;
        end else begin
          deb_cnt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Fault detection looks at the registered stable level. Values loaded this
  // edge are therefore first judged on the following edge.
  assign inconsistent = sens_stable[1] & ~sens_stable[2];

  // Main FSM. S_INIT waits for the synchroniser to fill, then loads the
  // stable levels directly. A startup load is not a change, so it emits no
  // strobe. S_RUN debounces and watches for persistent inconsistency.
  // S_FAULT keeps debouncing, holds fault high, and has no exit other than
  // reset.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state          <= S_INIT;
      init_cnt       <= '0;
      cnt            <= '0;
      pcnt           <= '0;
      sens_stable    <= '0;
      sens_valid     <= 1'b0;
      sens_change    <= 1'b0;
      fault          <= 1'b0;
      fault_snapshot <= '0;
    end else begin
      sens_change <= 1'b0;
      case (state)
        S_INIT: begin
          if (init_cnt == INIT_LAST) begin
            sens_stable <= sync2;
            sens_valid  <= 1'b1;
            state       <= S_RUN;
          end else begin
            init_cnt <= init_cnt + CNT_W'(1);
          end
        end
        S_RUN, S_FAULT: begin
          sens_stable <= deb_stable;
          cnt         <= deb_cnt;
          sens_change <= |deb_update;
          if (state == S_RUN) begin
            if (inconsistent) begin
              if (pcnt == PCNT_LAST) begin
                fault          <= 1'b1;
                fault_snapshot <= sens_stable;
                state          <= S_FAULT;
              end else begin
                pcnt <= pcnt + PCNT_W'(1);
              end
            end else begin
              pcnt <= '0;
            end
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

`ifdef LSC_GLITCH_CNT_EN
  logic glitch_abort;

  // A glitch is a debounce run that ends without an update. This happens
  // when a channel has a non-zero count and sync2 agrees with the stable
  // level again. Several channels aborting on one edge count as one glitch.
  always_comb begin
    glitch_abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ((cnt[i] != '0) && (sync2[i] == sens_stable[i])) begin
        glitch_abort = 1'b1;
      end
    end
  end

  // Saturating glitch counter. It counts only once debouncing is active.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      glitch_cnt <= '0;
    end else if ((state != S_INIT) && glitch_abort && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// tb_level_sensor_conditioner
//
// Self-checking bench for level_sensor_conditioner. It runs directed
// scenarios followed by a randomized soak. A behavioural model of the
// sensor rules runs alongside the DUT and supplies the expected values:
// - a switch level is believed after it has disagreed for DEBOUNCE_CYCLES
//   consecutive synchronised samples;
// - a fault follows FAULT_PERSIST consecutive inconsistent samples.
// Define LSC_GLITCH_CNT_EN to also check glitch_cnt.
// -----------------------------------------------------------------------------
module tb_level_sensor_conditioner;

  localparam int DEB = 4;
  localparam int FP  = 2;

  logic       clk_2;
  logic       reset;
  logic [2:0] sens_raw;
  logic [2:0] sens_stable;
  logic       sens_valid;
  logic       sens_change;
  logic       fault;
  logic [2:0] fault_snapshot;
`ifdef LSC_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [2:0] m_s1, m_s2, m_stable, m_snap;
  logic       m_valid, m_change, m_fault;
  int         m_edges, m_prun, m_glitch;
  int         m_run [3];

  level_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3),
    .FAULT_PERSIST(FP)
  ) dut (
    .clk_2(clk_2),
    .reset(reset),
    .sens_raw(sens_raw),
    .sens_stable(sens_stable),
    .sens_valid(sens_valid),
    .sens_change(sens_change),
    .fault(fault),
    .fault_snapshot(fault_snapshot)
`ifdef LSC_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Model of one clock edge, written from the sensor rules rather than the
  // RTL structure.
  function automatic void model_edge(input logic rst, input logic [2:0] raw);
    logic [2:0] old_stable;
    logic       chg;
    logic       abort;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_snap = '0;
      m_valid = 1'b0; m_change = 1'b0; m_fault = 1'b0;
      m_edges = 0; m_prun = 0; m_glitch = 0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      return;
    end
    old_stable = m_stable;
    chg = 1'b0;
    abort = 1'b0;
    if (!m_valid) begin
      m_edges++;
      if (m_edges == DEB + 2) begin
        m_stable = m_s2;
        m_valid = 1'b1;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != old_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_stable[i] = m_s2[i];
            m_run[i] = 0;
            chg = 1'b1;
          end
        end else begin
          if (m_run[i] != 0) abort = 1'b1;
          m_run[i] = 0;
        end
      end
      if (abort && m_glitch < 255) m_glitch++;
      if (!m_fault) begin
        if (old_stable[1] && !old_stable[2]) begin
          m_prun++;
          if (m_prun == FP) begin
            m_fault = 1'b1;
            m_snap = old_stable;
          end
        end else begin
          m_prun = 0;
        end
      end
    end
    m_change = chg;
    m_s2 = m_s1;
    m_s1 = raw;
  endfunction

  // Drive one cycle, advance the model over the same edge, and settle
  // before any sampling.
  task automatic step(input logic rst, input logic [2:0] raw);
    reset = rst;
    sens_raw = raw;
    @(posedge clk_2);
    model_edge(rst, raw);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 3'b101);
    step(1'b1, 3'b101);
    checks++; if (sens_stable !== 3'b000) begin failures++; $display("[TB] FAIL reset_stable got=%b exp=000", sens_stable); end
    checks++; if (sens_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", sens_valid); end
    checks++; if (sens_change !== 1'b0) begin failures++; $display("[TB] FAIL reset_change got=%b exp=0", sens_change); end
    checks++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (fault_snapshot !== 3'b000) begin failures++; $display("[TB] FAIL reset_snapshot got=%b exp=000", fault_snapshot); end
  endtask

  task automatic test_startup_fill(input string tag);
    for (int e = 1; e <= 6; e++) begin
      step(1'b0, 3'b101);
      checks++; if (sens_change !== 1'b0) begin failures++; $display("[TB] FAIL %s_change edge=%0d got=%b exp=0", tag, e, sens_change); end
      checks++; if (sens_valid !== (e == 6)) begin failures++; $display("[TB] FAIL %s_valid edge=%0d got=%b exp=%b", tag, e, sens_valid, (e == 6)); end
    end
    checks++; if (sens_stable !== 3'b101) begin failures++; $display("[TB] FAIL %s_stable got=%b exp=101", tag, sens_stable); end
    checks++; if (sens_stable !== m_stable) begin failures++; $display("[TB] FAIL %s_model_stable got=%b exp=%b", tag, sens_stable, m_stable); end
  endtask

  task automatic test_debounce_latency();
    int first_edge = 0;
    int pulses = 0;
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 3'b100);
      if (sens_change === 1'b1) pulses++;
      if (first_edge == 0 && sens_stable[0] === 1'b0) begin
        first_edge = e;
        checks++; if (sens_change !== 1'b1) begin failures++; $display("[TB] FAIL latency_strobe got=%b exp=1", sens_change); end
      end
    end
    checks++; if (first_edge != 6) begin failures++; $display("[TB] FAIL latency_edge got=%0d exp=6", first_edge); end
    checks++; if (pulses != 1) begin failures++; $display("[TB] FAIL latency_pulses got=%0d exp=1", pulses); end
    checks++; if (sens_stable !== 3'b100) begin failures++; $display("[TB] FAIL latency_stable got=%b exp=100", sens_stable); end
  endtask

  task automatic test_glitch_rejection();
    int pulses = 0;
    int moved = 0;
    for (int e = 1; e <= 3; e++) begin
      step(1'b0, 3'b000);
      if (sens_change === 1'b1) pulses++;
      if (sens_stable !== 3'b100) moved++;
    end
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 3'b100);
      if (sens_change === 1'b1) pulses++;
      if (sens_stable !== 3'b100) moved++;
    end
    checks++; if (moved != 0) begin failures++; $display("[TB] FAIL glitch_stable_moved got=%0d exp=0", moved); end
    checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL glitch_pulses got=%0d exp=0", pulses); end
`ifdef LSC_GLITCH_CNT_EN
    checks++; if (glitch_cnt !== 8'd1) begin failures++; $display("[TB] FAIL glitch_cnt got=%0d exp=1", glitch_cnt); end
`endif
  endtask

  task automatic test_multi_channel();
    int pulses = 0;
    int first_edge = 0;
    for (int e = 1; e <= 8; e++) step(1'b0, 3'b000);
    checks++; if (sens_stable !== 3'b000) begin failures++; $display("[TB] FAIL multi_pre got=%b exp=000", sens_stable); end
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 3'b110);
      if (sens_change === 1'b1) pulses++;
      if (first_edge == 0 && sens_stable !== 3'b000) begin
        first_edge = e;
        checks++; if (sens_stable !== 3'b110) begin failures++; $display("[TB] FAIL multi_same_edge got=%b exp=110", sens_stable); end
      end
    end
    checks++; if (first_edge != 6) begin failures++; $display("[TB] FAIL multi_edge got=%0d exp=6", first_edge); end
    checks++; if (pulses != 1) begin failures++; $display("[TB] FAIL multi_pulses got=%0d exp=1", pulses); end
    checks++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL multi_fault got=%b exp=0", fault); end
  endtask

  task automatic test_fault();
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 3'b011);
      if (e == 6) begin
        checks++; if (sens_stable !== 3'b011) begin failures++; $display("[TB] FAIL fault_stable got=%b exp=011", sens_stable); end
      end
      if (e == 7) begin
        checks++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL fault_early got=%b exp=0", fault); end
      end
    end
    checks++; if (fault !== 1'b1) begin failures++; $display("[TB] FAIL fault_rise got=%b exp=1", fault); end
    checks++; if (fault_snapshot !== 3'b011) begin failures++; $display("[TB] FAIL fault_snapshot got=%b exp=011", fault_snapshot); end
    for (int e = 1; e <= 8; e++) step(1'b0, 3'b101);
    checks++; if (sens_stable !== 3'b101) begin failures++; $display("[TB] FAIL fault_follow got=%b exp=101", sens_stable); end
    checks++; if (fault !== 1'b1) begin failures++; $display("[TB] FAIL fault_sticky got=%b exp=1", fault); end
    checks++; if (fault_snapshot !== 3'b011) begin failures++; $display("[TB] FAIL fault_snap_hold got=%b exp=011", fault_snapshot); end
  endtask

  task automatic test_reset_mid_fault();
    step(1'b1, 3'b101);
    checks++; if ({sens_stable, sens_valid, sens_change, fault, fault_snapshot} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got=%b/%b/%b/%b/%b exp=all zero", sens_stable, sens_valid, sens_change, fault, fault_snapshot);
    end
`ifdef LSC_GLITCH_CNT_EN
    checks++; if (glitch_cnt !== 8'd0) begin failures++; $display("[TB] FAIL midreset_glitch got=%0d exp=0", glitch_cnt); end
`endif
    test_startup_fill("refill");
  endtask

  task automatic test_random();
    logic [2:0] raw;
    int hold;
    int cyc = 0;
    raw = 3'b101;
    while (cyc < 600) begin
      raw = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        step(($urandom_range(0, 249) == 0), raw);
        cyc++;
        checks++; if (sens_stable !== m_stable) begin failures++; $display("[TB] FAIL rnd_stable cyc=%0d got=%b exp=%b", cyc, sens_stable, m_stable); end
        checks++; if (sens_valid !== m_valid) begin failures++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, sens_valid, m_valid); end
        checks++; if (sens_change !== m_change) begin failures++; $display("[TB] FAIL rnd_change cyc=%0d got=%b exp=%b", cyc, sens_change, m_change); end
        checks++; if (fault !== m_fault) begin failures++; $display("[TB] FAIL rnd_fault cyc=%0d got=%b exp=%b", cyc, fault, m_fault); end
        checks++; if (fault_snapshot !== m_snap) begin failures++; $display("[TB] FAIL rnd_snapshot cyc=%0d got=%b exp=%b", cyc, fault_snapshot, m_snap); end
`ifdef LSC_GLITCH_CNT_EN
        checks++; if (glitch_cnt !== 8'(m_glitch)) begin failures++; $display("[TB] FAIL rnd_glitch cyc=%0d got=%0d exp=%0d", cyc, glitch_cnt, m_glitch); end
`endif
      end
    end
  endtask

  // Watchdog: the bench is cycle-bounded. This guard only fires if
  // simulation time runs away.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    sens_raw = 3'b000;
    model_edge(1'b1, 3'b000);
    #1;
    test_reset();
    test_startup_fill("fill");
    test_debounce_latency();
    test_glitch_rejection();
    test_multi_channel();
    test_fault();
    test_reset_mid_fault();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/level_sensor_conditioner.md
Name: level_sensor_conditioner

Overview:
- Sits directly upstream of the pump-control FSM.
- Conditions the three raw level-sensor switch inputs (cistern min, tank max, tank min): it synchronises them, debounces them per channel, and publishes stable levels with a one-cycle change strobe.
- Detects a persistent tank-sensor inconsistency and raises a sticky fault that the pump FSM consumes.
- Runs entirely in the clk_2 domain.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised input must differ from the stable value before the stable value updates (≥2).
- CNT_W, 3: width of each debounce counter; must hold DEBOUNCE_CYCLES+1.
- FAULT_PERSIST, 2: consecutive cycles the stable value must be inconsistent before fault asserts (≥1).

Ports:
- Interface decision: reset reset, synchronous, active-high; clock clk_2.
- clk_2  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- sens_raw  in  3  raw switches: [0] cistern min, [1] tank max, [2] tank min.
- sens_stable  out  3  debounced levels, same bit order.
- sens_valid  out  1  high once the startup fill completes; stays high until reset.
- sens_change  out  1  one-cycle pulse when any sens_stable bit changes.
- fault  out  1  sticky tank-sensor inconsistency flag.
- fault_snapshot  out  3  sens_stable captured on the edge fault rises.

Behaviour:
- Reset values: sens_stable=0, sens_valid=0, sens_change=0, fault=0, fault_snapshot=0. All counters and synchroniser flops are 0; state=S_INIT.
- Reset mid-operation: every register returns to its reset value on that edge, including fault.
- Synchroniser: two flops per bit (sync1, sync2). All logic below uses sync2 only.
- FSM states:
  - S_INIT: a startup counter counts clk_2 edges after reset deasserts. On the (DEBOUNCE_CYCLES+2)th edge:
    - sens_stable <= sync2 directly, with no debouncing;
    - sens_valid <= 1;
    - go to S_RUN.
    - No sens_change pulse for this load.
  - S_RUN, per channel:
    - If sync2 != stable: cnt <= cnt+1.
    - If additionally cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
    - If sync2 == stable: cnt <= 0.
  - S_FAULT: debouncing continues exactly as in S_RUN; fault stays 1 until reset; no exit path.
- Latency: a raw change held constant from before edge k appears on sens_stable after the (DEBOUNCE_CYCLES+2)th edge counted from k (6th with defaults).
- Glitch rejection: a sync2 deviation lasting ≤ DEBOUNCE_CYCLES-1 cycles is rejected; the counter clears and sens_stable is unchanged.
- sens_change: registered. It is 1 for exactly the cycle after any stable bit updates. Several channels updating on the same edge produce a single pulse.
- Consistency rule: inconsistent = sens_stable[1] & ~sens_stable[2] (max wet while min dry).
- Fault persistence (S_RUN only):
  - A persistence counter increments each edge the registered sens_stable is inconsistent and clears when it is consistent.
  - When inconsistent and pcnt == FAULT_PERSIST-1 on the same edge: fault <= 1, fault_snapshot <= sens_stable, go to S_FAULT.
  - With FAULT_PERSIST=1, fault rises on the first edge that sees the inconsistency.
- Cistern bit [0] never contributes to fault.
- The inconsistency check is not evaluated in S_INIT. An inconsistent value loaded at the end of S_INIT is first counted on the following edge.

Optional Feature:
- Macro: LSC_GLITCH_CNT_EN.
- Defined:
  - Adds output glitch_cnt (8 bits, reset 0).
  - glitch_cnt increments by one, saturating at 255, on each edge where any channel's cnt is nonzero and is cleared by sync2 returning to stable without an update.
  - Several channels clearing on the same edge count once.
  - Counting is active in S_RUN and S_FAULT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Startup fill: reset 1 cycle with sens_raw=3'b101, then release -> sens_valid and sens_stable=3'b101 rise on the 6th edge after release; sens_change stays 0 throughout.
- Debounce latency: after valid, drive sens_raw[0] 1→0 and hold -> sens_stable[0]=0 after the 6th edge; sens_change high for exactly one cycle.
- Glitch rejection: toggle sens_raw[2] for 3 cycles, then restore -> sens_stable unchanged, no sens_change; glitch_cnt=1 when LSC_GLITCH_CNT_EN is defined.
- Multi-channel change: change bits 1 and 2 on the same cycle -> both stable bits update on the same edge; exactly one sens_change pulse.
- Fault: drive sens_raw=3'b011 and hold -> sens_stable=3'b011 after 6 edges, fault=1 two edges later, fault_snapshot=3'b011.
  - Then drive 3'b101 -> sens_stable follows; fault stays 1.
- Reset mid-fault: assert reset for 1 cycle while fault=1 -> all outputs 0 next edge, state S_INIT; startup fill repeats.
